// File: rtl/tlb_repl_ctrl.sv
// TLB victim selector: invalid-first, else LFSR-seeded search for the first unlocked entry.
// Optional random-eviction statistics counter enabled by macro TLB_REPL_STATS_EN.
module tlb_repl_ctrl #(
  parameter int NumEntries = 16,
  parameter int IdxWidth   = $clog2(NumEntries)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [NumEntries-1:0] entry_valid_i,
  input  logic [NumEntries-1:0] entry_lock_i,
  input  logic [IdxWidth-1:0]   rnd_i,
  output logic                  rnd_en_o,
  output logic                  victim_valid_o,
  output logic [IdxWidth-1:0]   victim_idx_o,
  input  logic                  victim_ack_i,
  output logic [31:0]           stats_rand_evict_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSelect = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  free_found;
  logic [IdxWidth-1:0]   free_idx;
  logic [NumEntries-1:0] rot_unlocked;
  logic                  rnd_found;
  logic [IdxWidth-1:0]   rnd_ofs;
  logic [IdxWidth-1:0]   rnd_idx;
  logic                  take_sel;
  logic [IdxWidth-1:0]   sel_idx;

  logic                  victim_valid_q, victim_valid_d;
  logic [IdxWidth-1:0]   victim_idx_q, victim_idx_d;

  // Lowest-index entry that is both invalid and unlocked; descending scan so the lowest wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (!entry_valid_i[i] && !entry_lock_i[i]) begin
        free_found = 1'b1;
        free_idx   = IdxWidth'(i);
      end
    end
  end

  // Rotate the unlocked mask so bit 0 corresponds to rnd_i; index arithmetic wraps mod NumEntries.
  always_comb begin
    rot_unlocked = '0;
    for (int i = 0; i < NumEntries; i++) begin
      rot_unlocked[i] = ~entry_lock_i[rnd_i + IdxWidth'(i)];
    end
  end

  always_comb begin
    rnd_found = 1'b0;
    rnd_ofs   = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (rot_unlocked[i]) begin
        rnd_found = 1'b1;
        rnd_ofs   = IdxWidth'(i);
      end
    end
  end

  assign rnd_idx  = rnd_i + rnd_ofs;
  assign sel_idx  = free_found ? free_idx : rnd_idx;
  assign take_sel = (state_q == StSelect) && !flush_i && (free_found || rnd_found);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:   if (req_valid_i) state_d = StSelect;
        StSelect: if (free_found || rnd_found) state_d = StHold;
        StHold:   if (victim_ack_i) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    rnd_en_o    = 1'b0;
    case (state_q)
      StIdle:   req_ready_o = !flush_i;
      StSelect: rnd_en_o    = !flush_i && !free_found && rnd_found;
      default: begin
        req_ready_o = 1'b0;
        rnd_en_o    = 1'b0;
      end
    endcase
  end

  always_comb begin
    victim_valid_d = victim_valid_q;
    victim_idx_d   = victim_idx_q;
    if (flush_i) begin
      victim_valid_d = 1'b0;
    end else if (take_sel) begin
      victim_valid_d = 1'b1;
      victim_idx_d   = sel_idx;
    end else if ((state_q == StHold) && victim_ack_i) begin
      victim_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_valid_q <= 1'b0;
      victim_idx_q   <= '0;
    end else begin
      victim_valid_q <= victim_valid_d;
      victim_idx_q   <= victim_idx_d;
    end
  end

  assign victim_valid_o = victim_valid_q;
  assign victim_idx_o   = victim_idx_q;

`ifdef TLB_REPL_STATS_EN
  logic [31:0] stats_q, stats_d;

  // Saturating; flush deliberately leaves it untouched.
  always_comb begin
    stats_d = stats_q;
    if (rnd_en_o && (stats_q != 32'hFFFF_FFFF)) begin
      stats_d = stats_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign stats_rand_evict_o = stats_q;
`else
  assign stats_rand_evict_o = '0;
`endif

  a_valid_iff_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    victim_valid_q == (state_q == StHold));
  a_rnd_en_in_select : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rnd_en_o |-> (state_q == StSelect));

endmodule
